// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the architectural register file.
package reg_file_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned ZERO_REG = 0;

    function automatic int unsigned reg_aw(input int unsigned nreg);
        return $clog2(nreg);
    endfunction

    typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one in-flight bit per register, set on issue, cleared on writeback or flush.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    localparam int unsigned AW = reg_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_dst,
    input  logic [1:0]      wr_en,
    input  logic [2*AW-1:0] wr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW-1:0]   wa0;
    logic [AW-1:0]   wa1;

    assign wa0 = wr_addr[0 +: AW];
    assign wa1 = wr_addr[AW +: AW];

    // A new producer outranks a same-cycle writeback of the old one.
    always_comb begin
        busy_d = busy_q;
        busy_d[ZERO_REG] = 1'b0;
        for (int r = 1; r < int'(NREG); r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_en && iss_dst == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if ((wr_en[0] && wa0 == AW'(r)) || (wr_en[1] && wa1 == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/multiport_reg_file.sv
// Architectural register file: NRD async read ports, two write ports, optional write bypass,
// plus an issue/writeback busy scoreboard.
module multiport_reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW = reg_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [1:0]        wr_en,
    input  logic [2*AW-1:0]   wr_addr,
    input  logic [2*XLEN-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_dst,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [AW-1:0]   wa [2];
    logic [XLEN-1:0] wd [2];
    logic [1:0]      wr_ok;

    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign wa[p]    = wr_addr[p*AW +: AW];
        assign wd[p]    = wr_data[p*XLEN +: XLEN];
        assign wr_ok[p] = wr_en[p] && (wa[p] != AW'(ZERO_REG));
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            if (wr_ok[0]) mem_q[wa[0]] <= wd[0];
            if (wr_ok[1]) mem_q[wa[1]] <= wd[1];
        end
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [1:0]      hit;
        logic            fwd;
        logic [XLEN-1:0] data;

        assign ra  = rd_addr[i*AW +: AW];
        assign hit = {wr_ok[1] && (wa[1] == ra), wr_ok[0] && (wa[0] == ra)};
        assign fwd = (BYPASS != 0) && !rst && (hit != 2'b00);

        always_comb begin
            data = mem_q[ra];
            if (fwd) begin
                data = hit[1] ? wd[1] : wd[0];
            end
            if (ra == AW'(ZERO_REG)) begin
                data = '0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        // Forwarded data is final, so the reader need not stall on it.
        assign rd_busy[i] = busy_vec[ra] && !fwd;
    end

    reg_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_multiport_reg_file.sv
// Self-checking bench for multiport_reg_file (default parameters, bypass enabled).
module tb_multiport_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ra0 = '0, ra1 = '0;
    logic [1:0]  we = '0;
    logic [4:0]  wa0 = '0, wa1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_dst = '0;
    logic        flush = 1'b0;

    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    multiport_reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  ({ra1, ra0}),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (we),
        .wr_addr  ({wa1, wa0}),
        .wr_data  ({wd1, wd0}),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] d;
        if (a == 0) return 32'h0;
        d = m_mem[a];
        if (!rst && we[0] && wa0 == a) d = wd0;
        if (!rst && we[1] && wa1 == a) d = wd1;
        return d;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (!rst && ((we[0] && wa0 == a) || (we[1] && wa1 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_commit();
        logic [31:0] nb;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_mem[r] = '0;
            m_busy = '0;
        end else begin
            nb = m_busy;
            for (int r = 1; r < 32; r++) begin
                if (flush) nb[r] = 1'b0;
                else if (iss_en && iss_dst == r) nb[r] = 1'b1;
                else if ((we[0] && wa0 == r) || (we[1] && wa1 == r)) nb[r] = 1'b0;
            end
            if (we[0] && wa0 != 0) m_mem[wa0] = wd0;
            if (we[1] && wa1 != 0) m_mem[wa1] = wd1;
            m_busy = nb;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        rst = 0; we = '0; iss_en = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        idle();
        for (int i = 0; i < 32; i++) begin
            ra0 = 5'(i);
            #1;
            checks++;
            if (rd_data[31:0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd r%0d got %h want 0", i, rd_data[31:0]);
            end
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy got %h want 0", busy_vec);
        end
    endtask

    task automatic test_bypass();
        ra0 = 5; we = 2'b01; wa0 = 5; wd0 = 32'hDEADBEEF;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same got %h want deadbeef", rd_data[31:0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_stored got %h want deadbeef", rd_data[31:0]);
        end
    endtask

    task automatic test_collision();
        ra1 = 7; we = 2'b11; wa0 = 7; wa1 = 7; wd0 = 32'h11111111; wd1 = 32'h22222222;
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h22222222) begin
            errors++;
            $display("FAIL collide_bypass got %h want 22222222", rd_data[63:32]);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h22222222) begin
            errors++;
            $display("FAIL collide_stored got %h want 22222222", rd_data[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        ra0 = 0; we = 2'b01; wa0 = 0; wd0 = 32'hFFFFFFFF; iss_en = 1; iss_dst = 0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_bypass got %h want 0", rd_data[31:0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || busy_vec[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg got data %h busy0 %b want 0/0", rd_data[31:0], busy_vec[0]);
        end
    endtask

    task automatic test_scoreboard();
        iss_en = 1; iss_dst = 9;
        step();
        idle();
        ra0 = 9;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || busy_vec[9] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue got %b/%b want 1/1", rd_busy[0], busy_vec[9]);
        end
        iss_en = 1; iss_dst = 9; we = 2'b01; wa0 = 9; wd0 = 32'h00000099;
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue_beats_wb got %b want 1", rd_busy[0]);
        end
        we = 2'b10; wa1 = 9; wd1 = 32'h00000999;
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || busy_vec[9] !== 1'b0 || rd_data[31:0] !== 32'h999) begin
            errors++;
            $display("FAIL sb_wb_clear got busy %b data %h want 0/999", rd_busy[0], rd_data[31:0]);
        end
    endtask

    task automatic test_flush_reset();
        iss_en = 1; iss_dst = 3;
        step();
        iss_dst = 4;
        step();
        idle();
        checks++;
        if (busy_vec !== 32'h18) begin
            errors++;
            $display("FAIL flush_pre got %h want 18", busy_vec);
        end
        flush = 1; iss_en = 1; iss_dst = 6;
        step();
        idle();
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL flush got %h want 0", busy_vec);
        end
        we = 2'b01; wa0 = 12; wd0 = 32'hAB;
        step();
        rst = 1; we = 2'b01; wa0 = 12; wd0 = 32'hCD; ra0 = 12; iss_en = 1; iss_dst = 12;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hAB) begin
            errors++;
            $display("FAIL rst_no_bypass got %h want ab", rd_data[31:0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid got %h busy %h want 0/0", rd_data[31:0], busy_vec);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            we      = 2'($urandom);
            wa0     = 5'($urandom);
            wa1     = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
            wd0     = $urandom;
            wd1     = $urandom;
            iss_en  = 1'($urandom);
            iss_dst = 5'($urandom);
            ra0     = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom);
            ra1     = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
            #1;
            checks++;
            if (rd_data[31:0] !== exp_rd(ra0) || rd_data[63:32] !== exp_rd(ra1)) begin
                errors++;
                $display("FAIL rand_rd it%0d got %h/%h want %h/%h", n, rd_data[31:0],
                         rd_data[63:32], exp_rd(ra0), exp_rd(ra1));
            end
            checks++;
            if (rd_busy !== {exp_busy(ra1), exp_busy(ra0)} || busy_vec !== m_busy) begin
                errors++;
                $display("FAIL rand_busy it%0d got %b %h want %b %h", n, rd_busy, busy_vec,
                         {exp_busy(ra1), exp_busy(ra0)}, m_busy);
            end
            step();
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_mem[r] = '0;
        m_busy = '0;
        #1;
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
